writeback_stage: RTL

- Final pipeline stage of the 8-bit core; consumes the execute stage's result, flags and decoded fields.
- Commits results to the register-file write port or the data-memory write port, and holds the architectural flag register.
- Sequences two-byte commits for multiply and divide, stalling execute with a valid/ready handshake.
- Implements halt and a retired-instruction counter.

---
 rtl/cpu_pkg.sv | 58 +++++
 rtl/wb_classify.sv | 43 ++++
 rtl/writeback_stage.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit core: opcodes, writeback FSM states,
// flag bit positions and the opcode-class bundle produced by wb_classify.
package cpu_pkg;

    localparam int OPCODE_W = 5;

    localparam logic [OPCODE_W-1:0] OP_MOV  = 5'b00000;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_INC  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_DEC  = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_XOR  = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_LD   = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_ST   = 5'b01100;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 5'b01101;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 5'b01110;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b10001;
    localparam logic [OPCODE_W-1:0] OP_RCL  = 5'b10010;
    localparam logic [OPCODE_W-1:0] OP_RCR  = 5'b10011;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b10100;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b10101;
    localparam logic [OPCODE_W-1:0] OP_JC   = 5'b10110;
    localparam logic [OPCODE_W-1:0] OP_CALL = 5'b10111;
    localparam logic [OPCODE_W-1:0] OP_RET  = 5'b11000;
    localparam logic [OPCODE_W-1:0] OP_CMP  = 5'b11001;
    localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11111;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WR_HI = 2'd1,
        HALT  = 2'd2
    } wb_state_t;

    // Bit positions inside the {Z,C,AC,P} flag register
    localparam int FLAG_Z  = 3;
    localparam int FLAG_C  = 2;
    localparam int FLAG_AC = 1;
    localparam int FLAG_P  = 0;

    typedef struct packed {
        logic is_alu;
        logic is_muldiv;
        logic is_store;
        logic is_flow;
        logic is_cmp;
        logic is_halt;
        logic upd_zp;
        logic upd_c;
        logic upd_ac;
    } wb_class_t;

endpackage

// File: rtl/wb_classify.sv
// Combinational opcode decoder: instruction class plus which flags it updates.
// Undefined opcodes decode to all-zero (no write, no flags, no retire).
module wb_classify
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0] opcode,
    output wb_class_t           cls
);

    always_comb begin
        cls = '0;
        case (opcode)
            OP_MOV, OP_LD: begin
                cls.is_alu = 1'b1;
            end
            OP_ADD, OP_SUB, OP_INC, OP_DEC: begin
                cls.is_alu = 1'b1;
                cls.upd_zp = 1'b1;
                cls.upd_c  = 1'b1;
                cls.upd_ac = 1'b1;
            end
            OP_SHL, OP_SHR, OP_RCL, OP_RCR: begin
                cls.is_alu = 1'b1;
                cls.upd_zp = 1'b1;
                cls.upd_c  = 1'b1;
            end
            OP_AND, OP_OR, OP_NOT, OP_XOR, OP_ROL, OP_ROR: begin
                cls.is_alu = 1'b1;
                cls.upd_zp = 1'b1;
            end
            OP_MUL, OP_DIV: begin
                cls.is_muldiv = 1'b1;
                cls.upd_zp    = 1'b1;
            end
            OP_ST:                               cls.is_store = 1'b1;
            OP_JMP, OP_JZ, OP_JC, OP_CALL, OP_RET: cls.is_flow  = 1'b1;
            OP_CMP:                              cls.is_cmp   = 1'b1;
            OP_HALT:                             cls.is_halt  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: commits results to the register file or data memory,
// owns the flag register, sequences two-byte mul/div commits and halt.
module writeback_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int RADDR_W     = 3,
    parameter int MADDR_W     = 4,
    parameter bit HI_WRITE_EN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [OPCODE_W-1:0]   opcode,
    input  logic [RADDR_W-1:0]    rd,
    input  logic [MADDR_W-1:0]    mem_addr,
    input  logic [2*DATA_W-1:0]   result,
    input  logic                  zero_in,
    input  logic                  carry_in,
    input  logic                  ac_in,
    input  logic                  parity_in,
    output logic                  rf_we,
    output logic [RADDR_W-1:0]    rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  dm_we,
    output logic [MADDR_W-1:0]    dm_addr,
    output logic [DATA_W-1:0]     dm_wdata,
    output logic [3:0]            flags_q,
    output logic                  halted,
    output logic [7:0]            retired
);

    // Handshake: an instruction is accepted on a clk edge where valid_in && ready_out.
    // While valid_in && !ready_out the upstream holds every input stable.
    wb_state_t state_q, state_d;
    wb_class_t cls;

    logic                accept;
    logic                retire;
    logic                z_calc, p_calc;
    logic                rf_we_d, dm_we_d;
    logic [RADDR_W-1:0]  rf_waddr_d, hi_addr_q, hi_addr_d;
    logic [DATA_W-1:0]   rf_wdata_d, dm_wdata_d, hi_data_q, hi_data_d;
    logic [MADDR_W-1:0]  dm_addr_d;
    logic [3:0]          flags_d;

    // Z and P are recomputed here; the execute-stage copies are not trusted.
    logic unused_flag_inputs;
    assign unused_flag_inputs = zero_in ^ parity_in;

    wb_classify u_classify (
        .opcode (opcode),
        .cls    (cls)
    );

    assign ready_out = (state_q == RUN) && reset;
    assign accept    = valid_in && ready_out;
    assign halted    = (state_q == HALT);

    always_comb begin
        z_calc = cls.is_muldiv ? (result == '0) : (result[DATA_W-1:0] == '0);
        p_calc = (opcode == OP_MUL) ? ^result : ^result[DATA_W-1:0];
    end

    always_comb begin
        state_d    = state_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr;
        rf_wdata_d = rf_wdata;
        dm_we_d    = 1'b0;
        dm_addr_d  = dm_addr;
        dm_wdata_d = dm_wdata;
        flags_d    = flags_q;
        hi_addr_d  = hi_addr_q;
        hi_data_d  = hi_data_q;
        retire     = 1'b0;

        case (state_q)
            RUN: begin
                if (accept) begin
                    if (cls.is_alu || cls.is_muldiv) begin
                        rf_we_d    = 1'b1;
                        rf_waddr_d = rd;
                        rf_wdata_d = result[DATA_W-1:0];
                    end
                    if (cls.is_store) begin
                        dm_we_d    = 1'b1;
                        dm_addr_d  = mem_addr;
                        dm_wdata_d = result[DATA_W-1:0];
                    end
                    // rd+1 wraps naturally at the register-address width (r7 -> r0)
                    if (cls.is_muldiv) begin
                        hi_data_d = result[2*DATA_W-1:DATA_W];
                        hi_addr_d = rd + RADDR_W'(1);
                        if (HI_WRITE_EN) state_d = WR_HI;
                        else             retire  = 1'b1;
                    end else if (cls.is_alu || cls.is_store || cls.is_flow ||
                                 cls.is_cmp || cls.is_halt) begin
                        retire = 1'b1;
                    end
                    if (cls.is_halt) state_d = HALT;

                    if (cls.upd_zp) begin
                        flags_d[FLAG_Z] = z_calc;
                        flags_d[FLAG_P] = p_calc;
                    end
                    if (cls.upd_c)  flags_d[FLAG_C]  = carry_in;
                    if (cls.is_cmp) flags_d[FLAG_C]  = result[0];
                    if (cls.upd_ac) flags_d[FLAG_AC] = ac_in;
                end
            end
            WR_HI: begin
                rf_we_d    = 1'b1;
                rf_waddr_d = hi_addr_q;
                rf_wdata_d = hi_data_q;
                retire     = 1'b1;
                state_d    = RUN;
            end
            HALT:    ;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RUN;
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdata  <= '0;
            dm_we     <= 1'b0;
            dm_addr   <= '0;
            dm_wdata  <= '0;
            flags_q   <= '0;
            retired   <= '0;
            hi_addr_q <= '0;
            hi_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rf_we     <= rf_we_d;
            rf_waddr  <= rf_waddr_d;
            rf_wdata  <= rf_wdata_d;
            dm_we     <= dm_we_d;
            dm_addr   <= dm_addr_d;
            dm_wdata  <= dm_wdata_d;
            flags_q   <= flags_d;
            hi_addr_q <= hi_addr_d;
            hi_data_q <= hi_data_d;
            if (retire) retired <= retired + 8'd1;
        end
    end

endmodule
